// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game sequencer and its environment (keyboard, player/collision, HUD).
// The sequencer connects through the slave modport.
interface game_flow_ctrl_if;
  logic [31:0] keycode;
  logic        game_over;
  logic        game_win_out;
  logic        enemy_hit;
  logic [1:0]  fsm_state;
  logic [1:0]  lives;
  logic [8:0]  time_left;
  logic        invuln;
  logic        end_is_win;

  modport master (
    output keycode, game_over, game_win_out, enemy_hit,
    input  fsm_state, lives, time_left, invuln, end_is_win
  );

  modport slave (
    input  keycode, game_over, game_win_out, enemy_hit,
    output fsm_state, lives, time_left, invuln, end_is_win
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: TITLE -> PLAYING -> DYING/END, owning lives, level timer
// and the post-respawn invulnerability window. Everything advances once per frame.
module game_flow_ctrl #(
  parameter int         LIVES_INIT      = 3,
  parameter int         TIME_INIT       = 400,
  parameter int         FRAMES_PER_TICK = 24,
  parameter int         DEATH_FRAMES    = 120,
  parameter int         INVULN_FRAMES   = 60,
  parameter logic [7:0] START_KEY       = 8'h28
) (
  input logic           frame_clk,
  input logic           Reset,
  game_flow_ctrl_if.slave bus
);

  localparam int TICK_W  = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK + 1) : 1;
  localparam int DEATH_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES + 1) : 1;
  localparam int INV_W   = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;

  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [8:0]         TIME_LOAD  = 9'(TIME_INIT);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAMES_PER_TICK - 1);
  localparam logic [DEATH_W-1:0] DEATH_LOAD = DEATH_W'(DEATH_FRAMES - 1);
  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    S_TITLE = 2'b00,
    S_PLAY  = 2'b01,
    S_DYING = 2'b10,
    S_END   = 2'b11
  } state_t;

  state_t             state_q;
  logic [1:0]         lives_q;
  logic [8:0]         time_q;
  logic [TICK_W-1:0]  tick_q;
  logic [DEATH_W-1:0] death_q;
  logic [INV_W-1:0]   inv_q;
  logic               key_prev_q;
  logic               win_q;

  logic key_now;
  logic start;
  logic unused_keycode_hi;

  assign key_now = (bus.keycode[7:0] == START_KEY) | (bus.keycode[15:8] == START_KEY);
  assign start   = key_now & ~key_prev_q;
  assign unused_keycode_hi = ^bus.keycode[31:16];

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_TITLE;
      lives_q    <= LIVES_LOAD;
      time_q     <= TIME_LOAD;
      tick_q     <= '0;
      death_q    <= '0;
      inv_q      <= '0;
      key_prev_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      key_prev_q <= key_now;
      case (state_q)
        S_TITLE: begin
          lives_q <= LIVES_LOAD;
          time_q  <= TIME_LOAD;
          win_q   <= 1'b0;
          if (start) begin
            state_q <= S_PLAY;
            tick_q  <= '0;
            inv_q   <= INV_LOAD;
          end
        end

        S_PLAY: begin
          // A win outranks any simultaneous death cause.
          if (bus.game_win_out) begin
            state_q <= S_END;
            win_q   <= 1'b1;
          end else if (bus.game_over || (time_q == 9'd0) ||
                       (bus.enemy_hit && (inv_q == '0))) begin
            state_q <= S_DYING;
            lives_q <= lives_q - 2'd1;
            death_q <= DEATH_LOAD;
          end else begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (time_q != 9'd0) time_q <= time_q - 9'd1;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
            if (inv_q != '0) inv_q <= inv_q - INV_W'(1);
          end
        end

        S_DYING: begin
          if (death_q == '0) begin
            if (lives_q == 2'd0) begin
              state_q <= S_END;
              win_q   <= 1'b0;
            end else begin
              state_q <= S_PLAY;
              time_q  <= TIME_LOAD;
              tick_q  <= '0;
              inv_q   <= INV_LOAD;
            end
          end else begin
            death_q <= death_q - DEATH_W'(1);
          end
        end

        // TITLE reloads its defaults on the frame after this transition.
        S_END: begin
          if (start) state_q <= S_TITLE;
        end

        default: state_q <= S_TITLE;
      endcase
    end
  end

  assign bus.fsm_state  = state_q;
  assign bus.lives      = lives_q;
  assign bus.time_left  = time_q;
  assign bus.invuln     = (inv_q != '0);
  assign bus.end_is_win = win_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: expectations are queued as stimulus is applied
// and popped/compared against the outputs once the frame has been clocked.
module tb_game_flow_ctrl;

  localparam int SEL_ST = 0;
  localparam int SEL_LV = 1;
  localparam int SEL_TM = 2;
  localparam int SEL_IV = 3;
  localparam int SEL_EW = 4;

  typedef struct {
    int         sel;
    logic [8:0] val;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if gif();

  game_flow_ctrl #(
    .LIVES_INIT     (3),
    .TIME_INIT      (400),
    .FRAMES_PER_TICK(24),
    .DEATH_FRAMES   (120),
    .INVULN_FRAMES  (60),
    .START_KEY      (8'h28)
  ) dut (
    .frame_clk(clk),
    .Reset    (rst),
    .bus      (gif.slave)
  );

  task automatic push(input int sel, input int v, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = 9'(v);
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [8:0] observe(input int sel);
    case (sel)
      SEL_ST:  return {7'd0, gif.fsm_state};
      SEL_LV:  return {7'd0, gif.lives};
      SEL_TM:  return gif.time_left;
      SEL_IV:  return {8'd0, gif.invuln};
      SEL_EW:  return {8'd0, gif.end_is_win};
      default: return '1;
    endcase
  endfunction

  task automatic drain();
    exp_t       e;
    logic [8:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic frame();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic push_reset_values(input string tag);
    push(SEL_ST, 0, {tag, "_state"});
    push(SEL_LV, 3, {tag, "_lives"});
    push(SEL_TM, 400, {tag, "_time"});
    push(SEL_IV, 0, {tag, "_invuln"});
    push(SEL_EW, 0, {tag, "_win"});
  endtask

  // One game_over pulse from PLAYING, then ride out the full death hold.
  task automatic lose_life(input int lives_after);
    gif.game_over = 1'b1;
    push(SEL_ST, 2, "pit_to_dying");
    push(SEL_LV, lives_after, "pit_lives_dec");
    frame();
    gif.game_over = 1'b0;
    for (int d = 1; d < 120; d++) begin
      push(SEL_ST, 2, "pit_dying_hold");
      frame();
    end
    if (lives_after == 0) begin
      push(SEL_ST, 3, "last_life_end");
      push(SEL_EW, 0, "last_life_not_win");
    end else begin
      push(SEL_ST, 1, "respawn_state");
      push(SEL_TM, 400, "respawn_time");
      push(SEL_IV, 1, "respawn_invuln");
    end
    frame();
    $display("lose_life: lives now %0d state %0d", gif.lives, gif.fsm_state);
  endtask

  initial begin
    rst              = 1'b1;
    gif.keycode      = 32'h0;
    gif.game_over    = 1'b0;
    gif.game_win_out = 1'b0;
    gif.enemy_hit    = 1'b0;
    #1;
    push_reset_values("reset");
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Enter held for five frames: exactly one start.
    gif.keycode = 32'h28;
    push(SEL_ST, 1, "start_state");
    push(SEL_LV, 3, "start_lives");
    push(SEL_TM, 400, "start_time");
    push(SEL_IV, 1, "start_invuln");
    frame();
    for (int i = 1; i < 5; i++) begin
      push(SEL_ST, 1, "held_key_state");
      push(SEL_IV, 1, "held_key_invuln");
      frame();
    end
    gif.keycode = 32'h0;
    $display("start: state %0d time %0d", gif.fsm_state, gif.time_left);

    // Free play; the enemy touch at frame 10 falls inside the immunity window.
    for (int p = 5; p < 70; p++) begin
      gif.enemy_hit = (p == 10);
      push(SEL_ST, 1, "play_state");
      push(SEL_TM, 400 - p / 24, "play_timer");
      push(SEL_IV, (p < 60) ? 1 : 0, "play_invuln");
      frame();
    end
    $display("play: 69 frames, time %0d invuln %0d", gif.time_left, gif.invuln);

    gif.enemy_hit = 1'b1;
    push(SEL_ST, 2, "enemy_to_dying");
    push(SEL_LV, 2, "enemy_lives_dec");
    frame();
    gif.enemy_hit = 1'b0;
    for (int d = 1; d < 120; d++) begin
      push(SEL_ST, 2, "enemy_dying_hold");
      push(SEL_LV, 2, "enemy_dying_lives");
      frame();
    end
    push(SEL_ST, 1, "enemy_respawn_state");
    push(SEL_TM, 400, "enemy_respawn_time");
    push(SEL_IV, 1, "enemy_respawn_invuln");
    push(SEL_LV, 2, "enemy_respawn_lives");
    frame();
    $display("enemy death: respawned with lives %0d", gif.lives);

    lose_life(1);
    lose_life(0);

    for (int i = 0; i < 3; i++) begin
      push(SEL_ST, 3, "end_hold_state");
      push(SEL_LV, 0, "end_hold_lives");
      push(SEL_EW, 0, "end_hold_win");
      frame();
    end

    gif.keycode = 32'h28;
    push(SEL_ST, 0, "end_to_title");
    push(SEL_LV, 0, "title_defaults_deferred");
    frame();
    push(SEL_ST, 0, "title_held_key");
    push(SEL_LV, 3, "title_lives_reload");
    push(SEL_TM, 400, "title_time_reload");
    push(SEL_EW, 0, "title_win_clear");
    frame();
    gif.keycode = 32'h0;
    push(SEL_ST, 0, "title_idle");
    frame();
    $display("end->title: lives %0d", gif.lives);

    // Win and pit in the same frame: the win takes it.
    gif.keycode = 32'h28;
    push(SEL_ST, 1, "second_game_start");
    frame();
    gif.keycode      = 32'h0;
    gif.game_win_out = 1'b1;
    gif.game_over    = 1'b1;
    push(SEL_ST, 3, "win_vs_pit_state");
    push(SEL_EW, 1, "win_vs_pit_flag");
    push(SEL_LV, 3, "win_vs_pit_lives");
    frame();
    gif.game_win_out = 1'b0;
    gif.game_over    = 1'b0;
    push(SEL_ST, 3, "win_end_hold");
    push(SEL_EW, 1, "win_end_flag_hold");
    push(SEL_TM, 400, "win_timer_frozen");
    frame();
    $display("win: end_is_win %0d lives %0d", gif.end_is_win, gif.lives);

    gif.keycode = 32'h28;
    push(SEL_ST, 0, "win_to_title");
    frame();
    gif.keycode = 32'h0;
    push(SEL_EW, 0, "title_after_win_flag");
    frame();
    gif.keycode = 32'h28;
    push(SEL_ST, 1, "third_game_start");
    frame();
    gif.keycode = 32'h0;

    // Let the level timer run out.
    for (int p = 1; p <= 9600; p++) begin
      if (p == 9599) push(SEL_TM, 1, "timer_last_tick");
      if (p == 9600) begin
        push(SEL_TM, 0, "timer_zero");
        push(SEL_ST, 1, "timer_zero_still_play");
      end
      frame();
    end
    push(SEL_ST, 2, "timeout_to_dying");
    push(SEL_LV, 2, "timeout_lives_dec");
    frame();
    $display("timeout: state %0d lives %0d", gif.fsm_state, gif.lives);

    for (int i = 0; i < 5; i++) begin
      push(SEL_ST, 2, "pre_reset_dying");
      frame();
    end
    #2;
    rst = 1'b1;
    #1;
    push_reset_values("async_reset");
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Start via the second keycode slot after the reset.
    gif.keycode = 32'h2800;
    push(SEL_ST, 1, "post_reset_start");
    push(SEL_IV, 1, "post_reset_invuln");
    push(SEL_TM, 400, "post_reset_time");
    push(SEL_LV, 3, "post_reset_lives");
    frame();
    gif.keycode = 32'h0;
    $display("reset recovery: state %0d", gif.fsm_state);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
